// File: rtl/pattern_det_seq.sv
// Feeds a valid/ready byte stream MSB-first into a bit-serial pattern detector, counts its hits
// and ends the run at a programmed target; in_ready is high only in FETCH, so peak rate is 9 cycles/byte.
module pattern_det_seq #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic [MAX_LEN-1:0] det_pattern,
    output logic [LEN_W-1:0]   det_len,
    output logic               det_clr,
    output logic               det_d,
    output logic               det_valid,
    input  logic               det_hit,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   hit_count,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tgt_q;
    logic [7:0]       byte_q;
    logic [2:0]       idx;
    logic [2:0]       idx_dec;

    logic             shadow_ld;
    logic             err_nxt;
    logic             cnt_en;
    logic             cnt_clr;
    logic             take;
    logic             shift_on;
    logic             det_d_nxt;
    logic [LEN_W-1:0] eff_len;
    logic [CNT_W-1:0] eff_tgt;
    logic             cfg_ok;
    logic             tgt_match;

    assign idx_dec = idx - 3'd1;

    always_comb begin
        state_nxt = state;
        shadow_ld = 1'b0;
        err_nxt   = err;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        take      = 1'b0;
        det_d_nxt = 1'b0;
        shift_on  = 1'b0;

        // A same-cycle write takes part in the legality check of a start.
        eff_len   = cfg_we ? cfg_len : det_len;
        eff_tgt   = cfg_we ? cfg_target : tgt_q;
        cfg_ok    = (eff_len != '0) && (eff_len <= LEN_W'(MAX_LEN)) && (eff_tgt != '0);
        tgt_match = (({1'b0, hit_count} + CNT_ONE) == {1'b0, tgt_q});

        case (state)
            IDLE: begin
                shadow_ld = cfg_we;
                if (start) begin
                    if (cfg_ok) begin
                        err_nxt   = 1'b0;
                        state_nxt = CLEAR;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end
            CLEAR: begin
                cnt_clr   = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                cnt_en = det_hit;
                if (det_hit && tgt_match) begin
                    state_nxt = DONE;
                end else if (in_valid && in_ready) begin
                    take      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                cnt_en = det_hit;
                if (det_hit && tgt_match) begin
                    state_nxt = DONE;
                end else if (idx == 3'd0) begin
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                // Hit belonging to the last bit sent before DONE.
                cnt_en    = det_hit;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE) begin
            if (cfg_we) begin
                err_nxt = 1'b1;
            end
            if (abort) begin
                state_nxt = IDLE;
                cnt_en    = 1'b0;
                cnt_clr   = 1'b0;
                take      = 1'b0;
            end
        end

        shift_on = (state == SHIFT) && (state_nxt == SHIFT);
        if (take) begin
            det_d_nxt = in_data[7];
        end else if (shift_on) begin
            det_d_nxt = byte_q[idx_dec];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            det_pattern <= '0;
            det_len     <= '0;
            tgt_q       <= '0;
            byte_q      <= '0;
            idx         <= '0;
            err         <= 1'b0;
            hit_count   <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            det_clr     <= 1'b0;
            done        <= 1'b0;
            det_valid   <= 1'b0;
            det_d       <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;

            if (shadow_ld) begin
                det_pattern <= cfg_pattern;
                det_len     <= cfg_len;
                tgt_q       <= cfg_target;
            end

            if (cnt_clr) begin
                hit_count <= '0;
            end else if (cnt_en && (hit_count != CNT_MAX)) begin
                hit_count <= hit_count + 1'b1;
            end

            // idx always names the bit currently presented on det_d.
            if (take) begin
                byte_q <= in_data;
                idx    <= 3'd7;
            end else if (shift_on) begin
                idx    <= idx_dec;
            end

            in_ready  <= (state_nxt == FETCH);
            busy      <= (state_nxt != IDLE);
            det_clr   <= (state_nxt == CLEAR);
            done      <= (state_nxt == DONE);
            det_valid <= (state_nxt == SHIFT);
            det_d     <= det_d_nxt;
        end
    end

endmodule

// File: tb/tb_pattern_det_seq.sv
// Directed bench for pattern_det_seq with a behavioural serial detector driving det_hit.
module tb_pattern_det_seq;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = '0;
    logic               in_ready;
    logic [MAX_LEN-1:0] det_pattern;
    logic [LEN_W-1:0]   det_len;
    logic               det_clr;
    logic               det_d;
    logic               det_valid;
    logic               det_hit;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   hit_count;
    logic               err;

    always #5 clk = ~clk;

    pattern_det_seq #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_target(cfg_target), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .det_pattern(det_pattern), .det_len(det_len), .det_clr(det_clr),
        .det_d(det_d), .det_valid(det_valid), .det_hit(det_hit), .busy(busy),
        .done(done), .hit_count(hit_count), .err(err)
    );

    // Detector model: registered hit, one cycle after the matching bit.
    logic               mdl_hit = 1'b0;
    logic               hit_ovr_en = 1'b0;
    logic               hit_ovr = 1'b0;
    logic [MAX_LEN-1:0] hist = '0;
    int                 seen = 0;
    logic               pend = 1'b0;

    assign det_hit = hit_ovr_en ? hit_ovr : mdl_hit;

    function automatic logic [7:0] len_mask(input logic [3:0] l);
        logic [8:0] m;
        m = (9'd1 << l) - 9'd1;
        return m[7:0];
    endfunction

    always @(negedge clk) begin
        if (!rst || det_clr) begin
            hist = '0;
            seen = 0;
            pend = 1'b0;
        end else if (det_valid) begin
            hist = {hist[MAX_LEN-2:0], det_d};
            if (seen < MAX_LEN) seen++;
            pend = (det_len != 0) && (seen >= int'(det_len)) &&
                   (((hist ^ det_pattern) & len_mask(det_len)) == 8'h00);
        end else begin
            pend = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1 mdl_hit = pend;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] all_outs();
        return {in_ready, det_pattern, det_len, det_clr, det_d, det_valid,
                busy, done, hit_count, err};
    endfunction

    typedef struct {
        logic       we;
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic [17:0] exp;   // {busy, err, det_clr, in_ready, done, det_valid, det_len, det_pattern}
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [7:0] pat, input logic [3:0] len,
                                input logic [7:0] tgt, input logic st, input logic ab,
                                input logic b, input logic e, input logic c, input logic r,
                                input logic [3:0] el, input logic [7:0] ep);
        vec_t v;
        v.we = we; v.pat = pat; v.len = len; v.tgt = tgt; v.st = st; v.ab = ab;
        v.exp = {b, e, c, r, 1'b0, 1'b0, el, ep};
        return v;
    endfunction

    // One full run from IDLE; poke >= 0 issues a config write in that run cycle.
    task automatic run(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt,
                       input logic [7:0] dat, input int poke,
                       output int bits, output int acc, output bit fin);
        bits = 0; acc = 0; fin = 1'b0;
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_target = tgt; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = dat;
        for (int n = 0; n < 200 && !fin; n++) begin
            tick();
            cfg_we = 1'b0;
            if (det_valid) bits++;
            if (in_valid && in_ready) acc++;
            if (done) fin = 1'b1;
            if (n == poke) begin
                cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd8; cfg_target = 8'd1;
            end
        end
        in_valid = 1'b0; cfg_we = 1'b0;
        tick();
    endtask

    vec_t tbl[14];
    int   bits, acc, bad, vc;
    bit   fin;
    logic [7:0] got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(1, 8'h15, 4'd5, 8'd2, 0, 0,  0, 0, 0, 0, 4'd5, 8'h15);
        tbl[1]  = mk(1, 8'h33, 4'd0, 8'd2, 1, 0,  0, 1, 0, 0, 4'd0, 8'h33);
        tbl[2]  = mk(1, 8'h44, 4'd9, 8'd2, 1, 0,  0, 1, 0, 0, 4'd9, 8'h44);
        tbl[3]  = mk(1, 8'h06, 4'd3, 8'd0, 1, 0,  0, 1, 0, 0, 4'd3, 8'h06);
        tbl[4]  = mk(0, 8'h77, 4'd3, 8'd1, 1, 0,  0, 1, 0, 0, 4'd3, 8'h06);
        tbl[5]  = mk(1, 8'h05, 4'd3, 8'd1, 1, 0,  1, 0, 1, 0, 4'd3, 8'h05);
        tbl[6]  = mk(1, 8'hFF, 4'd8, 8'd4, 0, 0,  1, 1, 0, 1, 4'd3, 8'h05);
        tbl[7]  = mk(0, 8'h00, 4'd0, 8'd0, 0, 1,  0, 1, 0, 0, 4'd3, 8'h05);
        tbl[8]  = mk(0, 8'h00, 4'd0, 8'd0, 1, 0,  1, 0, 1, 0, 4'd3, 8'h05);
        tbl[9]  = mk(0, 8'h00, 4'd0, 8'd0, 0, 1,  0, 0, 0, 0, 4'd3, 8'h05);
        tbl[10] = mk(1, 8'h80, 4'd8, 8'd1, 1, 0,  1, 0, 1, 0, 4'd8, 8'h80);
        tbl[11] = mk(0, 8'h00, 4'd0, 8'd0, 0, 1,  0, 0, 0, 0, 4'd8, 8'h80);
        tbl[12] = mk(1, 8'h01, 4'd1, 8'd1, 1, 0,  1, 0, 1, 0, 4'd1, 8'h01);
        tbl[13] = mk(0, 8'h00, 4'd0, 8'd0, 0, 1,  0, 0, 0, 0, 4'd1, 8'h01);

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Config / start / abort vectors
        for (int i = 0; i < 14; i++) begin
            cfg_we = tbl[i].we; cfg_pattern = tbl[i].pat; cfg_len = tbl[i].len;
            cfg_target = tbl[i].tgt; start = tbl[i].st; abort = tbl[i].ab;
            tick();
            chk($sformatf("vec%0d", i),
                64'({busy, err, det_clr, in_ready, done, det_valid, det_len, det_pattern}),
                64'(tbl[i].exp));
        end
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
        tick();

        // 10101, target 2: both hits inside the first 0xAA
        run(8'h15, 4'd5, 8'd2, 8'hAA, -1, bits, acc, fin);
        chk("t2_done", 64'(fin), 64'd1);
        chk("t2_bits", 64'(bits), 64'd8);
        chk("t2_accepts", 64'(acc), 64'd1);
        chk("t2_hit_count", 64'(hit_count), 64'd2);

        // target 3: third hit lands on bit 9, rest of second byte discarded
        run(8'h15, 4'd5, 8'd3, 8'hAA, -1, bits, acc, fin);
        chk("t2b_done", 64'(fin), 64'd1);
        chk("t2b_bits", 64'(bits), 64'd10);
        chk("t2b_accepts", 64'(acc), 64'd2);
        chk("t2b_hit_count", 64'(hit_count), 64'd3);

        // Config write while running is rejected and flagged
        run(8'h15, 4'd5, 8'd2, 8'hAA, 3, bits, acc, fin);
        chk("t4_done", 64'(fin), 64'd1);
        chk("t4_hit_count", 64'(hit_count), 64'd2);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_det_pattern", 64'(det_pattern), 64'h15);
        chk("t4_det_len", 64'(det_len), 64'd5);

        // Abort in the same cycle as a target-reaching hit
        cfg_we = 1'b1; cfg_pattern = 8'h15; cfg_len = 4'd5; cfg_target = 8'd1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        tick();
        chk("t5_in_fetch", 64'(in_ready), 64'd1);
        hit_ovr_en = 1'b1; hit_ovr = 1'b1; abort = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        tick();
        hit_ovr_en = 1'b0; hit_ovr = 1'b0; abort = 1'b0; in_valid = 1'b0;
        chk("t5_idle", 64'({busy, in_ready, det_valid}), 64'd0);
        fin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) fin = 1'b1;
            tick();
        end
        chk("t5_no_done", 64'(fin), 64'd0);
        chk("t5_hit_count", 64'(hit_count), 64'd0);
        hit_ovr_en = 1'b1; hit_ovr = 1'b1;
        repeat (3) tick();
        hit_ovr_en = 1'b0; hit_ovr = 1'b0;
        chk("t5_idle_hit_ignored", 64'(hit_count), 64'd0);

        // Long FETCH stall, then first valid byte goes straight out MSB-first
        cfg_we = 1'b1; cfg_pattern = 8'h15; cfg_len = 4'd5; cfg_target = 8'd200; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        tick();
        cfg_we = 1'b1; cfg_pattern = 8'hFF;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(in_ready && !det_valid)) bad++;
            tick();
            cfg_we = 1'b0;
        end
        chk("t6_stall", 64'(bad), 64'd0);
        chk("t6_err", 64'(err), 64'd1);
        chk("t6_det_pattern", 64'(det_pattern), 64'h15);
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        got = '0; vc = 0;
        for (int i = 0; i < 8; i++) begin
            got[7-i] = det_d;
            if (det_valid) vc++;
            tick();
        end
        chk("t6_bits", 64'(got), 64'h5A);
        chk("t6_valid_cycles", 64'(vc), 64'd8);
        chk("t6_back_to_fetch", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of a byte
        in_valid = 1'b1; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("t1_mid_shift", 64'({busy, det_valid}), 64'h3);
        #2 rst = 1'b0;
        #1;
        chk("t1_async_reset", 64'(all_outs()), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t1_after_reset", 64'(all_outs()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
